// File: rtl/multi_tick_generator_pkg.sv
// multi_tick_generator_pkg
//   Shared constants and types for the multi-channel tick generator.
//   TICK_CNT_W / TICK_MAX_CH size the production build; PERIOD_CORE and
//   PERIOD_READ are the processor-core and sensor-read rates in system-clock
//   cycles; PERIOD_SIM_* are short equivalents for simulation builds.
package multi_tick_generator_pkg;

  localparam int unsigned TICK_CNT_W      = 26;
  localparam int unsigned TICK_MAX_CH     = 8;

  localparam int unsigned PERIOD_CORE     = 10000001;
  localparam int unsigned PERIOD_READ     = 5000001;

  localparam int unsigned PERIOD_SIM_CORE = 3;
  localparam int unsigned PERIOD_SIM_READ = 2;

  // What a channel does on the coming edge.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,   // disabled or period 0: freeze count and square
    ACT_COUNT = 2'd1,   // advance the counter
    ACT_WRAP  = 2'd2,   // last cycle of the period: tick, toggle, reload
    ACT_SYNC  = 2'd3    // global restart
  } ch_action_e;

endpackage

// File: rtl/multi_tick_generator_tick_channel.sv
// tick_channel
//   One channel of the tick generator: free-running counter, active and
//   shadow period registers, registered tick strobe and square wave.
//
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   en         run enable
//   sync       restart counter and square, reload active period
//   wr_en      period write addressed to this channel
//   wr_period  period value for the write (0 stops the channel)
//   tick       registered single-cycle strobe at each period wrap
//   square     registered square wave, toggles at each tick
module tick_channel
  import multi_tick_generator_pkg::*;
#(
  parameter int unsigned      CNT_W        = TICK_CNT_W,
  parameter logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(PERIOD_CORE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_period,
  output logic             tick,
  output logic             square
);

  ch_action_e       action;

  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             tick_q,   tick_d;
  logic             square_q, square_d;

  logic             at_wrap;
  logic [CNT_W-1:0] load_period;

  // A write in the same cycle as a reload wins over the old shadow value.
  assign load_period = wr_en ? wr_period : shadow_q;

  // '>=' rather than '==': a period shortened while the channel was held
  // can leave the count above P-1; it then wraps on the next enabled edge
  // instead of running round the whole counter range.
  assign at_wrap = (cnt_q >= (active_q - CNT_W'(1)));

  always_comb begin
    action = ACT_HOLD;
    if (sync) begin
      action = ACT_SYNC;
    end else if (en && (active_q != '0)) begin
      action = at_wrap ? ACT_WRAP : ACT_COUNT;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    shadow_d = wr_en ? wr_period : shadow_q;
    tick_d   = 1'b0;
    square_d = square_q;

    unique case (action)
      ACT_SYNC: begin
        cnt_d    = '0;
        square_d = 1'b0;
        active_d = load_period;
      end
      ACT_WRAP: begin
        cnt_d    = '0;
        tick_d   = 1'b1;
        square_d = ~square_q;
        active_d = load_period;
      end
      ACT_COUNT: begin
        cnt_d    = cnt_q + CNT_W'(1);
      end
      default: begin
        // Held channel: no period in progress, so a write applies at once.
        if (wr_en) begin
          active_d = wr_period;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= RESET_PERIOD;
      shadow_q <= RESET_PERIOD;
      tick_q   <= 1'b0;
      square_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      tick_q   <= tick_d;
      square_q <= square_d;
    end
  end

  assign tick   = tick_q;
  assign square = square_q;

endmodule

// File: rtl/multi_tick_generator.sv
// multi_tick_generator
//   NUM_CH independent tick strobes and 50%-duty square waves derived from
//   one system clock. Ticks are clock enables, not clocks.
//
//   n_clock     system clock, rising edge
//   n_reset     synchronous active-low reset
//   en          per-channel run enable
//   sync        global restart / phase alignment of all channels
//   cfg_we      period write strobe
//   cfg_ch      channel index for the write
//   cfg_period  new period in cycles (0 stops the channel)
//   tick        per-channel registered single-cycle strobe
//   square      per-channel registered square wave
//   cfg_err     registered pulse after a write to a non-existent channel
module multi_tick_generator
  import multi_tick_generator_pkg::*;
#(
  parameter int unsigned             NUM_CH         = 2,
  parameter int unsigned             CNT_W          = TICK_CNT_W,
  parameter int unsigned             CH_W           = 1,
  parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_PERIOD = {CNT_W'(PERIOD_READ), CNT_W'(PERIOD_CORE)}
) (
  input  logic              n_clock,
  input  logic              n_reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] square,
  output logic              cfg_err
);

  logic [NUM_CH-1:0] wr_sel;
  logic              cfg_err_q, cfg_err_d;

  // An out-of-range index matches no channel, so the write is dropped.
  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg_we && (32'(cfg_ch) == i);
    end
  end

  always_comb begin
    cfg_err_d = cfg_we && (32'(cfg_ch) >= NUM_CH);
  end

  always_ff @(posedge n_clock) begin
    if (!n_reset) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (DEFAULT_PERIOD[g*CNT_W +: CNT_W])
    ) u_ch (
      .clk       (n_clock),
      .rst_n     (n_reset),
      .en        (en[g]),
      .sync      (sync),
      .wr_en     (wr_sel[g]),
      .wr_period (cfg_period),
      .tick      (tick[g]),
      .square    (square[g])
    );
  end

endmodule

// File: tb/tb_multi_tick_generator.sv
module tb_multi_tick_generator;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CH_W   = 2;

  logic              n_clock = 1'b0;
  logic              n_reset;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] square;
  logic              cfg_err;

  int checks   = 0;
  int failures = 0;

  // Expected {ch1,ch0} after each of the first six edges after reset release
  // with periods ch0=3, ch1=2.
  logic [1:0] exp_tick [6] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b11};
  logic [1:0] exp_sq   [6] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b01, 2'b10};

  always #5 n_clock = ~n_clock;

  multi_tick_generator #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (CNT_W),
    .CH_W           (CH_W),
    .DEFAULT_PERIOD ({4'd2, 4'd3})
  ) dut (
    .n_clock    (n_clock),
    .n_reset    (n_reset),
    .en         (en),
    .sync       (sync),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .tick       (tick),
    .square     (square),
    .cfg_err    (cfg_err)
  );

  task automatic step();
    @(posedge n_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] p);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_period = p;
  endtask

  initial begin
    n_reset    = 1'b0;
    en         = 2'b11;
    sync       = 1'b0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;

    // Reset values
    step();
    step();
    chk("reset_tick", 8'(tick), 8'h0);
    chk("reset_square", 8'(square), 8'h0);
    chk("reset_cfg_err", 8'(cfg_err), 8'h0);
    n_reset = 1'b1;

    // Default periods 3 and 2 (edges 1..6)
    for (int i = 0; i < 6; i++) begin
      step();
      chk("default_tick", 8'(tick), 8'(exp_tick[i]));
      chk("default_square", 8'(square), 8'(exp_sq[i]));
    end

    // Deferred write: ch0 period 3 -> 5 while cnt=1
    step();                               // e7, ch0 cnt=1
    write(2'd0, 4'd5);
    step();                               // e8
    cfg_we = 1'b0;
    chk("defer_e8_tick0", 8'(tick[0]), 8'h0);
    step();                               // e9: old period completes
    chk("defer_e9_tick0", 8'(tick[0]), 8'h1);
    chk("defer_e9_sq0", 8'(square[0]), 8'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("defer_gap1_tick0", 8'(tick[0]), 8'h0);
    end
    step();                               // e14
    chk("defer_e14_tick0", 8'(tick[0]), 8'h1);
    chk("defer_e14_sq0", 8'(square[0]), 8'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("defer_gap2_tick0", 8'(tick[0]), 8'h0);
    end
    step();                               // e19
    chk("defer_e19_tick0", 8'(tick[0]), 8'h1);

    // Enable hold on ch1 at cnt=0
    step();                               // e20
    step();                               // e21
    step();                               // e22: ch1 wraps
    chk("hold_e22_tick1", 8'(tick[1]), 8'h1);
    chk("hold_e22_sq1", 8'(square[1]), 8'h1);
    en = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_gap_tick1", 8'(tick[1]), 8'h0);
      chk("hold_gap_sq1", 8'(square[1]), 8'h1);
    end
    en = 2'b11;
    step();                               // e27
    chk("hold_e27_tick1", 8'(tick[1]), 8'h0);
    step();                               // e28
    chk("hold_e28_tick1", 8'(tick[1]), 8'h1);
    chk("hold_e28_sq1", 8'(square[1]), 8'h0);

    // Sync alignment with both periods 4
    write(2'd0, 4'd4);
    step();                               // e29
    write(2'd1, 4'd4);
    step();                               // e30
    cfg_we = 1'b0;
    step();                               // e31
    step();                               // e32
    sync = 1'b1;
    step();                               // e33
    sync = 1'b0;
    chk("sync_tick", 8'(tick), 8'h0);
    chk("sync_square", 8'(square), 8'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sync_gap_tick", 8'(tick), 8'h0);
    end
    step();                               // e37
    chk("sync_align_tick", 8'(tick), 8'h3);
    chk("sync_align_square", 8'(square), 8'h3);

    // Period 1 written together with sync (write-through)
    write(2'd1, 4'd1);
    sync = 1'b1;
    step();                               // e38
    cfg_we = 1'b0;
    sync   = 1'b0;
    chk("p1_sync_tick", 8'(tick), 8'h0);
    chk("p1_sync_square", 8'(square), 8'h0);
    for (int i = 0; i < 3; i++) begin
      step();                             // e39..e41
      chk("p1_tick1", 8'(tick[1]), 8'h1);
      chk("p1_sq1", 8'(square[1]), 8'((i + 1) % 2));
    end

    // Period 0: wrap in the write cycle loads the new (zero) period
    write(2'd1, 4'd0);
    step();                               // e42
    cfg_we = 1'b0;
    chk("p0_wrap_tick1", 8'(tick[1]), 8'h1);
    chk("p0_wrap_sq1", 8'(square[1]), 8'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("p0_tick1", 8'(tick[1]), 8'h0);
      chk("p0_sq1", 8'(square[1]), 8'h0);
    end

    // Restart from period 0: loads immediately
    write(2'd1, 4'd2);
    step();                               // e47
    cfg_we = 1'b0;
    chk("restart_e47_tick1", 8'(tick[1]), 8'h0);
    step();                               // e48
    chk("restart_e48_tick1", 8'(tick[1]), 8'h0);
    step();                               // e49
    chk("restart_e49_tick1", 8'(tick[1]), 8'h1);
    chk("restart_e49_sq1", 8'(square[1]), 8'h1);
    chk("no_err_before", 8'(cfg_err), 8'h0);

    // Invalid channel index
    write(2'd3, 4'd7);
    step();                               // e50
    cfg_we = 1'b0;
    chk("inv_cfg_err", 8'(cfg_err), 8'h1);
    chk("inv_e50_tick", 8'(tick), 8'h1);
    step();                               // e51
    chk("inv_cfg_err_clear", 8'(cfg_err), 8'h0);
    chk("inv_e51_tick", 8'(tick), 8'h2);
    step();                               // e52
    chk("inv_e52_tick", 8'(tick), 8'h0);
    step();                               // e53
    chk("inv_e53_tick", 8'(tick), 8'h2);
    step();                               // e54
    chk("inv_e54_tick", 8'(tick), 8'h1);
    chk("inv_e54_square", 8'(square), 8'h2);

    // Mid-run reset for one edge restores defaults
    n_reset = 1'b0;
    step();
    n_reset = 1'b1;
    chk("midreset_tick", 8'(tick), 8'h0);
    chk("midreset_square", 8'(square), 8'h0);
    chk("midreset_cfg_err", 8'(cfg_err), 8'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midreset_tick_seq", 8'(tick), 8'(exp_tick[i]));
      chk("midreset_sq_seq", 8'(square), 8'(exp_sq[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
